surf_dout_framer: RTL and testbench

SURF_DOUT_FRAMER -- requirements
Module: surf_dout_framer

---
 rtl/surf_dout_framer.sv | 217 +++++++++++++++++++++
 tb/tb_surf_dout_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surf_dout_framer.sv
// DOUT byte-stream framer: HEADER/LEN/payload/CHK -> 32-bit stream words via an internal FWFT FIFO.
// Latency: word enters FIFO one cycle after its last byte, m_tvalid_o the cycle after; no input stall, whole-frame drop when FIFO lacks room.
// Optional checksum checking enabled by defining SURF_DOUT_FRAMER_CHECKSUM_EN.
module surf_dout_framer #(
    parameter int         FIFO_DEPTH = 64,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic        sysclk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [7:0]  dout_data_i,
    input  logic        dout_valid_i,
    output logic [31:0] m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] drop_count_o,
    output logic [15:0] err_count_o,
    output logic        busy_o
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     DEPTH16  = 16'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = 1;
    localparam logic [AW:0]     OCC_ONE  = 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [9:0]  skip_cnt_q, skip_cnt_d;
    logic [31:0] word_q, word_d;
    logic        wr_vld_q, wr_vld_d;
    logic [33:0] wr_dat_q, wr_dat_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [33:0]   head;
    logic          rd_en;

    logic          chk_mis;
    logic [15:0]   byte_ext;
    logic [15:0]   occ_ext;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef SURF_DOUT_FRAMER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (dout_valid_i) begin
            case (state_q)
                S_LEN:     sum_d = dout_data_i;
                S_PAYLOAD: sum_d = sum_q + dout_data_i;
                default:   sum_d = sum_q;
            endcase
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) sum_q <= 8'd0;
        else       sum_q <= sum_d;
    end

    assign chk_mis = (dout_data_i != sum_q);
`else
    assign chk_mis = 1'b0;
`endif

    assign byte_ext = {8'd0, dout_data_i};
    // Count a still-pending write as occupied so the room check is never optimistic.
    assign occ_ext  = 16'(occ_q) + 16'(wr_vld_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        word_d      = word_q;
        wr_vld_d    = 1'b0;
        wr_dat_d    = wr_dat_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (dout_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i && dout_data_i == HEADER) state_d = S_LEN;
                end
                S_LEN: begin
                    len_d      = dout_data_i;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 8'd0;
                    if (dout_data_i == 8'd0 || byte_ext > DEPTH16) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        state_d   = S_IDLE;
                    end else if (occ_ext > DEPTH16 - byte_ext) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        skip_cnt_d = {dout_data_i, 2'b00} + 10'd1;
                        state_d    = S_SKIP;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = dout_data_i;
                        2'd1:    word_d[15:8]  = dout_data_i;
                        2'd2:    word_d[23:16] = dout_data_i;
                        default: word_d[31:24] = dout_data_i;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_cnt_q == len_q - 8'd1) begin
                            state_d = S_CHECK;
                        end else begin
                            wr_vld_d   = 1'b1;
                            wr_dat_d   = {2'b00, dout_data_i, word_q[23:0]};
                            word_cnt_d = word_cnt_q + 8'd1;
                        end
                    end
                end
                S_CHECK: begin
                    wr_vld_d    = 1'b1;
                    wr_dat_d    = {chk_mis, 1'b1, word_q};
                    frame_cnt_d = sat_inc(frame_cnt_q);
                    if (chk_mis) err_cnt_d = sat_inc(err_cnt_q);
                    state_d     = S_IDLE;
                end
                S_SKIP: begin
                    skip_cnt_d = skip_cnt_q - 10'd1;
                    if (skip_cnt_q == 10'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rd_en = m_tvalid_o & m_tready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_vld_q) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en)    rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_vld_q && !rd_en)      occ_d = occ_q + OCC_ONE;
        else if (!wr_vld_q && rd_en) occ_d = occ_q - OCC_ONE;
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= 8'd0;
            word_cnt_q  <= 8'd0;
            byte_cnt_q  <= 2'd0;
            skip_cnt_q  <= 10'd0;
            word_q      <= 32'd0;
            wr_vld_q    <= 1'b0;
            wr_dat_q    <= 34'd0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            word_q      <= word_d;
            wr_vld_q    <= wr_vld_d;
            wr_dat_q    <= wr_dat_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Storage needs no reset: entries are only visible through occ_q.
    always_ff @(posedge sysclk_i) begin
        if (wr_vld_q) mem_q[wr_ptr_q] <= wr_dat_q;
    end

    assign head          = mem_q[rd_ptr_q];
    assign m_tvalid_o    = (occ_q != '0);
    assign m_tdata_o     = m_tvalid_o ? head[31:0] : 32'd0;
    assign m_tlast_o     = m_tvalid_o & head[32];
    assign m_tuser_o     = m_tvalid_o & head[33];
    assign frame_count_o = frame_cnt_q;
    assign drop_count_o  = drop_cnt_q;
    assign err_count_o   = err_cnt_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_surf_dout_framer.sv
// Directed self-checking bench for surf_dout_framer (default FIFO_DEPTH 64, HEADER A5).
module tb_surf_dout_framer;

`ifdef SURF_DOUT_FRAMER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  dout_data;
    logic        dout_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic [15:0] err_count;
    logic        busy;

    surf_dout_framer #(.FIFO_DEPTH(64), .HEADER(8'hA5)) dut (
        .sysclk_i      (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .dout_data_i   (dout_data),
        .dout_valid_i  (dout_valid),
        .m_tdata_o     (m_tdata),
        .m_tvalid_o    (m_tvalid),
        .m_tready_i    (m_tready),
        .m_tlast_o     (m_tlast),
        .m_tuser_o     (m_tuser),
        .frame_count_o (frame_count),
        .drop_count_o  (drop_count),
        .err_count_o   (err_count),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int e_frames = 0;
    int e_err    = 0;
    int e_drop   = 0;

    logic [33:0] rx_q[$];
    logic [33:0] exp_q[$];
    logic [7:0]  tx_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfers happen on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) rx_q.push_back({m_tuser, m_tlast, m_tdata});
    end

    task automatic build_frame(input int len, input logic [7:0] seed, input bit bad, input bit accept);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(len));
        sum = 8'(len);
        for (int i = 0; i < len; i++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                b = seed + 8'(i * 4 + j);
                w[j*8 +: 8] = b;
                sum = sum + b;
                tx_q.push_back(b);
            end
            if (accept)
                exp_q.push_back({1'(bad && CHK_EN && (i == len - 1)), 1'(i == len - 1), w});
        end
        tx_q.push_back(bad ? sum + 8'd1 : sum);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        dout_valid = 1'b1;
        dout_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dout_valid = 1'b0;
        end
    endtask

    task automatic send_tx();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
        idle(1);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (rx_q.size() < exp_q.size() && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_rx(input string tag);
        chk({tag, "_words"}, 64'(rx_q.size()), 64'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0)
            chk(tag, 64'(rx_q.pop_front()), 64'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frames"}, 64'(frame_count), 64'(e_frames));
        chk({tag, "_errs"},   64'(err_count),   64'(e_err));
        chk({tag, "_drops"},  64'(drop_count),  64'(e_drop));
    endtask

    // Checksum covers LEN as well: 02 + (01+..+08) = 0x26.
    logic [7:0] f1 [11] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
    int         ntx;
    logic [7:0] txa [$];

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        dout_valid = 1'b0;
        dout_data  = 8'h00;
        m_tready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast",  64'(m_tlast),  64'd0);
        chk("rst_tuser",  64'(m_tuser),  64'd0);
        chk("rst_tdata",  64'(m_tdata),  64'd0);
        chk("rst_busy",   64'(busy),     64'd0);
        chk_counters("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic two-word frame
        enable   = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 11; i++) send_byte(f1[i]);
        idle(1);
        exp_q.push_back({2'b00, 32'h04030201});
        exp_q.push_back({2'b01, 32'h08070605});
        drain(50);
        compare_rx("basic");
        e_frames = 1;
        chk_counters("basic");

        // Same frame with a wrong checksum byte
        for (int i = 0; i < 10; i++) send_byte(f1[i]);
        send_byte(8'h25);
        idle(1);
        exp_q.push_back({2'b00, 32'h04030201});
        exp_q.push_back({CHK_EN, 1'b1, 32'h08070605});
        drain(50);
        compare_rx("badchk");
        e_frames = 2;
        e_err    = CHK_EN ? 1 : 0;
        chk_counters("badchk");

        // Illegal lengths 0 and 65
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("len0_busy", 64'(busy), 64'd1);
        send_byte(8'hA5);
        send_byte(8'h41);
        idle(3);
        e_err = e_err + 2;
        chk_counters("badlen");
        chk("badlen_busy", 64'(busy), 64'd0);
        chk("badlen_out", 64'(rx_q.size()), 64'd0);

        // Reset in the middle of a frame with words pending
        m_tready = 1'b0;
        build_frame(2, 8'h10, 1'b0, 1'b1);
        send_tx();
        idle(3);
        chk("prerst_tvalid", 64'(m_tvalid), 64'd1);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h30);
        send_byte(8'h31);
        send_byte(8'h32);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_tvalid", 64'(m_tvalid), 64'd0);
        chk("async_busy",   64'(busy),     64'd0);
        chk("async_frames", 64'(frame_count), 64'd0);
        dout_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_tready = 1'b1;
        build_frame(2, 8'h40, 1'b0, 1'b1);
        send_tx();
        drain(50);
        compare_rx("postrst");
        e_frames = 1;
        e_err    = 0;
        e_drop   = 0;
        chk_counters("postrst");

        // Drop on insufficient room, with first-word fall-through timing
        m_tready = 1'b0;
        build_frame(40, 8'h00, 1'b0, 1'b1);
        ntx = tx_q.size();
        for (int i = 0; i < ntx; i++) begin
            send_byte(tx_q.pop_front());
            if (i == 6) chk("fwft_pre", 64'(m_tvalid), 64'd0);
            if (i == 7) chk("fwft",     64'(m_tvalid), 64'd1);
        end
        build_frame(30, 8'h80, 1'b0, 1'b0);
        chk("drop_bytes", 64'(tx_q.size()), 64'd123);
        ntx = tx_q.size();
        for (int i = 0; i < ntx; i++) begin
            send_byte(tx_q.pop_front());
            if (i == 60) chk("skip_busy", 64'(busy), 64'd1);
        end
        idle(1);
        chk("drop_idle", 64'(busy), 64'd0);
        e_frames = 2;
        e_drop   = 1;
        chk_counters("drop");
        m_tready = 1'b1;
        drain(200);
        compare_rx("drop");
        chk("drop_empty", 64'(m_tvalid), 64'd0);

        // Full-depth frame fits an empty FIFO; any further frame is then dropped
        m_tready = 1'b0;
        build_frame(64, 8'hC0, 1'b0, 1'b1);
        send_tx();
        build_frame(1, 8'h01, 1'b0, 1'b0);
        send_tx();
        idle(2);
        e_frames = 3;
        e_drop   = 2;
        chk_counters("full");
        m_tready = 1'b1;
        drain(300);
        compare_rx("full");

        // Gapped input with random backpressure; payload contains the header byte
        build_frame(1, 8'hA3, 1'b0, 1'b1);
        build_frame(3, 8'h5A, 1'b1, 1'b1);
        build_frame(2, 8'hF0, 1'b0, 1'b1);
        while (tx_q.size() > 0) begin
            @(posedge clk);
            #1;
            dout_valid = 1'b1;
            dout_data  = tx_q.pop_front();
            m_tready   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            dout_valid = 1'b0;
            m_tready   = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
        drain(100);
        compare_rx("gapped");
        e_frames = 6;
        e_err    = CHK_EN ? 1 : 0;
        chk_counters("gapped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
